// File: rtl/decade_tick_scheduler.sv
`timescale 1ns/1ps
// Single-clock decade divider: cascaded mod-10 digits produce one-cycle enables and
// square waves for run-time selectable channels, with glitch-free reconfiguration.
module decade_tick_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int DECADES = 7
) (
  input  logic               CLOCK_10MHz,
  input  logic               RESET,
  input  logic               START,
  input  logic               STOP,
  input  logic               CLEAR,
  input  logic               CFG_VALID,
  output logic               CFG_READY,
  input  logic [2:0]         CFG_CH,
  input  logic [2:0]         CFG_SEL,
  output logic               RUNNING,
  output logic [DECADES-1:0] DEC_TICK,
  output logic [NUM_CH-1:0]  TICK,
  output logic [NUM_CH-1:0]  SQ,
  output logic [NUM_CH-1:0]  CFG_PENDING
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e             state_q;
  logic [3:0]         digit_q  [DECADES];
  logic [3:0]         digit_d  [DECADES];
  logic [DECADES-1:0] all_nines;
  logic [DECADES-1:0] dec_tick_q, dec_tick_d;
  logic [2:0]         sel_q    [NUM_CH];
  logic [2:0]         sel_d    [NUM_CH];
  logic [2:0]         shadow_q [NUM_CH];
  logic [2:0]         shadow_d [NUM_CH];
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  sq_q, sq_d;
  logic [NUM_CH-1:0]  ch_hit, apply, accept;
  logic               count_en;
  logic [2:0]         cfg_sel_clean;

  assign count_en = (state_q == ST_RUN) && !CLEAR;

  // all_nines[k]: digits 0..k are all 9, i.e. stage k is about to wrap.
  always_comb begin
    for (int k = 0; k < DECADES; k++) begin
      all_nines[k] = 1'b1;
      for (int j = 0; j <= k; j++)
        if (digit_q[j] != 4'd9) all_nines[k] = 1'b0;
    end
  end

  always_comb begin
    logic carry;
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    carry = 1'b1;
    for (int k = 0; k < DECADES; k++) digit_d[k] = digit_q[k];
    if (CLEAR) begin
      for (int k = 0; k < DECADES; k++) digit_d[k] = 4'd0;
    end else if (state_q == ST_RUN) begin
      for (int k = 0; k < DECADES; k++) begin
        if (carry) digit_d[k] = (digit_q[k] == 4'd9) ? 4'd0 : digit_q[k] + 4'd1;
        carry = carry && (digit_q[k] == 4'd9);
      end
    end
  end

  assign dec_tick_d = count_en ? all_nines : '0;

  always_comb begin
    TICK = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int k = 0; k < DECADES; k++)
        if (sel_q[ch] == 3'(k + 1)) TICK[ch] = dec_tick_q[k];
  end

  // Out-of-range selects collapse to "off" rather than indexing past the chain.
  assign cfg_sel_clean = (int'(CFG_SEL) > DECADES) ? 3'd0 : CFG_SEL;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ch_hit[ch] = (CFG_CH == 3'(ch));
      apply[ch]  = pending_q[ch] &&
                   (TICK[ch] || (sel_q[ch] == 3'd0) || (state_q == ST_IDLE) || CLEAR);
    end
  end

  assign CFG_READY = !(CFG_VALID && |(ch_hit & apply));
  assign accept    = {NUM_CH{CFG_VALID && CFG_READY}} & ch_hit;

  // A shadow is applied at the end of the tick cycle, so the old-rate tick still goes out.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sel_d[ch]     = sel_q[ch];
      shadow_d[ch]  = shadow_q[ch];
      pending_d[ch] = pending_q[ch];
      if (apply[ch]) begin
        sel_d[ch]     = shadow_q[ch];
        pending_d[ch] = 1'b0;
      end
      if (accept[ch]) begin
        shadow_d[ch]  = cfg_sel_clean;
        pending_d[ch] = 1'b1;
      end
      sq_d[ch] = 1'b0;
      for (int k = 0; k < DECADES; k++)
        if (sel_d[ch] == 3'(k + 1)) sq_d[ch] = (digit_d[k] >= 4'd5);
    end
  end

  // STOP wins over a simultaneous START.
  always_ff @(posedge CLOCK_10MHz or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (START && !STOP) state_q <= ST_RUN;
        ST_RUN:  if (STOP)           state_q <= ST_IDLE;
        default:                     state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_10MHz or posedge RESET) begin
    if (RESET) begin
      // NOTE: the digit and select arrays are plain flops, not RAM, so they take the async reset.
      for (int k = 0; k < DECADES; k++) digit_q[k] <= 4'd0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sel_q[ch]    <= 3'd0;
        shadow_q[ch] <= 3'd0;
      end
      dec_tick_q <= '0;
      pending_q  <= '0;
      sq_q       <= '0;
    end else begin
      // NOTE: sequential state is written only with non-blocking assignments.
      for (int k = 0; k < DECADES; k++) digit_q[k] <= digit_d[k];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sel_q[ch]    <= sel_d[ch];
        shadow_q[ch] <= shadow_d[ch];
      end
      dec_tick_q <= dec_tick_d;
      pending_q  <= pending_d;
      sq_q       <= sq_d;
    end
  end

  assign RUNNING     = (state_q == ST_RUN);
  assign DEC_TICK    = dec_tick_q;
  assign SQ          = sq_q;
  assign CFG_PENDING = pending_q;

endmodule
